// File: rtl/hvac_pkg.sv
// Shared state encodings for the HVAC actuator stage.
package hvac_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_HEAT    = 3'd1,
        ST_COOL    = 3'd2,
        ST_FAN_OVR = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

endpackage

// File: rtl/hvac_actuator_hold_timer.sv
// Loadable down-counter that parks at zero; drives the actuator's dwell timing.
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hvac_actuator.sv
// Equipment-protection sequencer: turns heat/cool demand into heater, cooler and
// fan enables while enforcing minimum run, fan overrun and restart lockout.
module hvac_actuator
    import hvac_pkg::*;
#(
    parameter int MIN_ON  = 4,
    parameter int FAN_RUN = 2,
    parameter int MIN_OFF = 3,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         heating,
    input  logic         cooling,
    output logic         heater_en,
    output logic         cooler_en,
    output logic         fan_en,
    output logic         conflict,
    output logic [2:0]   state
);

    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] FAN_LD = CNT_W'(FAN_RUN - 1);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(MIN_OFF - 1);

    state_t           state_q;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             zero;

    // {heater, cooler, fan} for the state being entered
    function automatic logic [2:0] drive(state_t s);
        case (s)
            ST_HEAT:    return 3'b101;
            ST_COOL:    return 3'b011;
            ST_FAN_OVR: return 3'b001;
            default:    return 3'b000;
        endcase
    endfunction

    // A timer load marks every departure except the final LOCKOUT -> IDLE step,
    // so the FSM keys its transitions off the same decision.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE: begin
                load     = heating ^ cooling;
                load_val = ON_LD;
            end
            ST_HEAT: begin
                load     = zero && (!heating || cooling);
                load_val = FAN_LD;
            end
            ST_COOL: begin
                load     = zero && (!cooling || heating);
                load_val = FAN_LD;
            end
            ST_FAN_OVR: begin
                load     = zero;
                load_val = OFF_LD;
            end
            default: begin
                load     = 1'b0;
                load_val = '0;
            end
        endcase
    end

    hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                          <= ST_IDLE;
            {heater_en, cooler_en, fan_en}   <= 3'b000;
            conflict                         <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    conflict <= heating & cooling;
                    if (load) begin
                        state_q                        <= heating ? ST_HEAT : ST_COOL;
                        {heater_en, cooler_en, fan_en} <= drive(heating ? ST_HEAT : ST_COOL);
                    end
                end
                ST_HEAT, ST_COOL: begin
                    if (load) begin
                        state_q                        <= ST_FAN_OVR;
                        {heater_en, cooler_en, fan_en} <= drive(ST_FAN_OVR);
                    end
                end
                ST_FAN_OVR: begin
                    if (load) begin
                        state_q                        <= ST_LOCKOUT;
                        {heater_en, cooler_en, fan_en} <= drive(ST_LOCKOUT);
                    end
                end
                ST_LOCKOUT: begin
                    if (zero) begin
                        state_q                        <= ST_IDLE;
                        {heater_en, cooler_en, fan_en} <= drive(ST_IDLE);
                    end
                end
                default: begin
                    state_q                        <= ST_IDLE;
                    {heater_en, cooler_en, fan_en} <= drive(ST_IDLE);
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: doc/hvac_actuator.md
# hvac_actuator

Downstream stage of the air-conditioning controller: consumes its `heating`/`cooling` demand bits and drives the physical heater, cooler and fan enables. Enforces equipment-protection timing: minimum run time, fan overrun after each run, and a minimum off (lockout) time before any restart. Prevents short-cycling and direct heat↔cool reversal regardless of how the demand bits toggle.

## Interface
- `MIN_ON`, default 4: minimum cycles heater/cooler stays enabled once started (≥1).
- `FAN_RUN`, default 2: fan-only overrun cycles after heater/cooler switches off (≥1).
- `MIN_OFF`, default 3: lockout cycles with everything off before a new request is accepted (≥1).
- `CNT_W`, default 8: hold-timer width; all timing parameters ≤ 2^CNT_W.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `heating`  in  1  heat demand from the AC controller.
- `cooling`  in  1  cool demand from the AC controller.
- `heater_en`  out  1  heater drive.
- `cooler_en`  out  1  cooler/compressor drive.
- `fan_en`  out  1  circulation fan drive.
- `conflict`  out  1  registered flag: both demands seen in IDLE.
- `state`  out  3  current FSM state (debug/verification).

## Operation
- States: IDLE=0, HEAT=1, COOL=2, FAN_OVR=3, LOCKOUT=4; encodings 5–7 illegal → next state IDLE.
- Outputs Moore-decoded from state: HEAT → heater_en=1, fan_en=1; COOL → cooler_en=1, fan_en=1; FAN_OVR → fan_en=1; IDLE/LOCKOUT → all 0. heater_en and cooler_en never both 1.
- IDLE: `heating & !cooling` → HEAT, cnt ← MIN_ON-1; `cooling & !heating` → COOL, cnt ← MIN_ON-1; both → stay IDLE, conflict ← 1; neither → stay, conflict ← 0.
- HEAT: cnt≠0 → decrement, stay. cnt=0 → leave to FAN_OVR (cnt ← FAN_RUN-1) if `!heating | cooling`, else stay (cnt held at 0).
- COOL: mirror of HEAT with `!cooling | heating`.
- FAN_OVR: cnt≠0 → decrement; cnt=0 → LOCKOUT, cnt ← MIN_OFF-1.
- LOCKOUT: cnt≠0 → decrement; cnt=0 → IDLE. Demands ignored throughout.
- No direct HEAT↔COOL transition; reversal always traverses FAN_OVR, LOCKOUT, IDLE.
- conflict updates only in IDLE; cleared on leaving IDLE.

## Timing
- Reset (async): state=IDLE, cnt=0, all outputs 0 immediately on `rst` rising, without a clock edge. Reset mid-run bypasses fan overrun and lockout by design.
- Start latency: demand sampled at edge N in IDLE → enable high from edge N (same cycle state becomes HEAT/COOL).
- Single-cycle demand pulse: heater/cooler high exactly MIN_ON cycles, fan high MIN_ON+FAN_RUN cycles, then MIN_OFF all-off cycles, then IDLE.
- Held demand: enable stays high; drops at first edge, after MIN_ON elapsed, at which demand is sampled low.
- Fastest restart: earliest acceptance is the first edge after re-entering IDLE, i.e. period ≥ MIN_ON+FAN_RUN+MIN_OFF+1 cycles.
- Counter never wraps: decrement only when ≠0.

## Structure
- Package `hvac_pkg`: state encodings, state width (3).
- Sub-module `hold_timer`: loadable CNT_W down-counter with `load`, `load_val`, `zero` output; FSM in `hvac_actuator` top.

## Test plan
- Reset: `rst`=1 with `heating`=1 → all enables 0, state=0; assert `rst` mid-HEAT → heater_en/fan_en drop with no clock edge.
- Defaults, `heating` pulse 1 cycle → heater_en high 4 cycles, fan_en high 6 cycles, then 3 cycles all 0, state returns 0.
- `heating` held 10 cycles → heater_en high 10 cycles, then fan 2, lockout 3.
- `heating` 1 cycle then `cooling` held → heater 4, fan-only 2, lockout 3, IDLE 1 cycle, cooler_en rises on next edge; never overlaps heater_en.
- `heating`=`cooling`=1 in IDLE → no enable, conflict=1 one edge later; release → conflict=0.
- After reset release mid-run, `heating`=1 → heater_en high on first edge (no lockout).
